mdu_iter: RTL

- Iterative multiply/divide unit for the MIPS32 five-stage pipeline. Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI and MTLO.
- Sits beside the ALU in EX. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.
- Parametrised in operand width. Adds abort-on-flush and defined divide-by-zero/overflow results; none of this exists in the current ALU path.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_iter_step.sv | 34 +++
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and controller states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, restoring shift-subtract for divide. Purely combinational.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply keeps the multiplier in the low half and retires one bit per step;
  // the extra sum bit holds the carry that is shifted back into the top.
  assign add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

  // Divide keeps the partial remainder in the high half and the dividend,
  // progressively replaced by quotient bits, in the low half.
  assign rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, opnd_i};

  always_comb begin
    if (is_div_i) begin
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0],   acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO, MTHI/MTLO,
// abort on flush and defined divide-by-zero results.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dzp_q, dzp_d;

  logic               is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_res, rem_res;
  logic [2*WIDTH-1:0] prod_res;

  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign is_div    = (op_q == MDU_DIVU) || (op_q == MDU_DIV);
  assign a_neg     = is_signed && a_q[WIDTH-1];
  assign b_neg     = is_signed && b_q[WIDTH-1];
  assign a_abs     = a_neg ? -a_q : a_q;
  assign b_abs     = b_neg ? -b_q : b_q;

  // The most-negative dividend negates to itself, which is already the
  // correct unsigned magnitude, so the overflow case needs no special path.
  assign prod_res  = neg_res_q ? -acc_q : acc_q;
  assign quo_res   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_res   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dzp_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = a;
        if (mtlo) lo_d = a;
        if (start) begin
          op_d    = mdu_op_e'(op);
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        acc_d     = {{WIDTH{1'b0}}, a_abs};
        opnd_d    = b_abs;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        dz_d      = is_div && (b_q == '0);
        cnt_d     = CNT_W'(WIDTH);
        state_d   = (is_div && (b_q == '0)) ? S_FIX : S_RUN;
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else if (is_div) begin
          lo_d = quo_res;
          hi_d = rem_res;
        end else begin
          {hi_d, lo_d} = prod_res;
        end
        done_d  = 1'b1;
        dzp_d   = dz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A squash discards the operation outright, including one finishing now.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dzp_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      op_q      <= MDU_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dzp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dzp_q     <= dzp_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dzp_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
